franken_dmem: RTL and testbench
===============================

# franken_dmem

Data-side memory responder for the single-cycle `franken_riscv` core; it sits at the other end of the core's data port. It serves word reads combinationally and commits byte-enabled writes on the clock edge into a word-addressed RAM. It also decodes a small MMIO window containing a GPIO register, a console transmit FIFO with a valid/ready output, a status register, and a free-running cycle counter.

## Interface
- `DEPTH_WORDS`, 1024, RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 4, console TX FIFO entries; power of two, 2..16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address; driven by the core's ALU result.
- `mem_write`  in  1  write strobe for the current cycle.
- `byte_enable`  in  4  lane enables; bit i selects bits [8i+7:8i].
- `write_data`  in  32  lane-placed store data.
- `read_data`  out  32  read word; combinational from `addr`.
- `gpio_out`  out  32  GPIO register contents.
- `tx_data`  out  8  byte at the FIFO head.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  console consumer accepts `tx_data` this cycle.

## Operation
- RAM region: `addr < DEPTH_WORDS*4`. Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
  - A write merges only the enabled lanes.
  - A read returns the full word. The core does lane extraction.
- MMIO region: `addr[31:4] == 0x1000000`. Register selected by `addr[3:2]`:
  - 0x0 GPIO: read/write, byte-enable merged.
  - 0x4 TXDATA:
    - A write with `byte_enable[0]` pushes `write_data[7:0]`.
    - Reads return 0.
  - 0x8 STATUS:
    - bit0 empty, bit1 full, bit2 overflow (sticky), bits[8:4] count.
    - Any write clears overflow.
  - 0xC CYCLE:
    - Reads return the counter.
    - A write with `byte_enable==4'b1111` loads `write_data`.
    - Partial writes are ignored.
- Unmapped addresses: reads return 0; writes are ignored.
- FIFO push:
  - Accepted when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- FIFO pop: occurs when `tx_valid & tx_ready`.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is held separately, 0..FIFO_DEPTH.
- Cycle counter:
  - Increments every cycle and wraps from 0xFFFFFFFF to 0.
  - A write load takes priority over the increment in that cycle.
- No RAM contents are reset.
- Reset values:
  - `gpio_out`=0, `tx_valid`=0, `tx_data`=0 (FIFO storage reset to 0).
  - Count=0, pointers=0, overflow=0, counter=0.
  - `read_data` follows `addr` combinationally, including during reset.

## Timing
- Read latency 0: `read_data` is valid in the same cycle as `addr`.
- Writes commit at the rising edge where `mem_write`=1.
- A read of a location in the same cycle as a write to it returns the pre-edge value.
- Push to an empty FIFO: `tx_valid` rises the cycle after the edge. There is no bypass.
- `tx_data` changes only on the edge after a pop, or a push into an empty FIFO.
- STATUS and CYCLE reads reflect the registered, pre-edge state.
- Reset assertion mid-operation:
  - Immediately (asynchronously) empties the FIFO and drops `tx_valid`.
  - Clears GPIO and the counter.
- Deassertion is synchronized externally. The block needs no reset synchronizer.

## Configuration
- `FRANKEN_DMEM_CYCLE_COUNTER_EN` defined: the CYCLE register behaves as above.
- `FRANKEN_DMEM_CYCLE_COUNTER_EN` undefined:
  - No counter flops are synthesized.
  - Offset 0xC reads 0 and ignores writes.

## Structure
- Shared package `franken_pkg`:
  - Region base constants: RAM base 0x0000_0000, MMIO base 0x1000_0000.
  - MMIO offsets: GPIO, TXDATA, STATUS, CYCLE.
  - STATUS bit positions.
- Sub-module `franken_tx_fifo`:
  - Parameterized by `FIFO_DEPTH`.
  - Ports: push/push_data, pop, head, empty, full, count.
  - Same clock and reset.
- The top level holds the address decoder, byte-merge logic, RAM array, GPIO, overflow flag and counter.

## Test plan
- Write 0xDEADBEEF to 0x10 (be=1111), then write `{0xAA,24'h0}` to 0x13 (be=1000) -> reading 0x10 returns 0xAAADBEEF.
- With `tx_ready`=0 and `FIFO_DEPTH`=4, push 0x41..0x45 on five cycles -> STATUS = full=1, overflow=1, count=4. Then `tx_ready`=1 -> `tx_data` shows 0x41, 0x42, 0x43, 0x44 on consecutive cycles; 0x45 never appears; `tx_valid` falls after the fourth pop.
- FIFO full with `tx_ready`=1 and a push of 0x55 in the same cycle -> count stays 4, overflow stays 0, and 0x55 is the last byte out.
- Write 0xFFFFFFFE to CYCLE -> reads on the next two cycles return 0xFFFFFFFF then 0x00000000. Write CYCLE with be=0011 -> value unaffected.
- Push 2 bytes and set GPIO=0x12345678, then pulse `reset` low mid-cycle -> `tx_valid`=0 and `gpio_out`=0 before the next edge; STATUS reads empty=1, count=0.
- Write 0xCAFEF00D to 0x2000_0000 -> a read there returns 0. Read of `DEPTH_WORDS*4` (first address past RAM) returns 0. RAM word 0 is unchanged.

Source files
------------

// File: rtl/franken_pkg.sv
// Shared constants for the franken_riscv data-side memory map: region bases,
// MMIO register selects, STATUS bit layout and the lane-merge helper.
package franken_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

    // Word select within the 16-byte MMIO window (addr[3:2]).
    typedef enum logic [1:0] {
        MMIO_GPIO   = 2'd0,
        MMIO_TXDATA = 2'd1,
        MMIO_STATUS = 2'd2,
        MMIO_CYCLE  = 2'd3
    } mmio_reg_e;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERFLOW  = 2;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 5;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/franken_tx_fifo.sv
// Console transmit byte FIFO: registered head, no push-to-output bypass,
// a push into a full FIFO is accepted only when a pop happens in the same cycle.
module franken_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/franken_dmem.sv
// Data-port responder for franken_riscv: combinational word reads, byte-enabled
// RAM writes and an MMIO window (GPIO, console TX FIFO, STATUS, CYCLE).
// Build option: FRANKEN_DMEM_CYCLE_COUNTER_EN enables the CYCLE counter.
module franken_dmem
    import franken_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_write,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          ram_sel;
    logic          mmio_sel;
    mmio_reg_e     reg_sel;
    logic          unused_addr_lsbs;

    logic [31:0]   gpio_q;
    logic          overflow_q;
    logic [31:0]   status_word;
    logic [31:0]   cycle_word;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          push_dropped;

    // Word accesses only; the core handles sub-word lane placement.
    assign unused_addr_lsbs = ^addr[1:0];

    assign word_idx = addr[AW+1:2];
    assign ram_sel  = (addr[31:AW+2] == RAM_BASE[31:AW+2]);
    assign mmio_sel = (addr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel  = mmio_reg_e'(addr[3:2]);

    assign fifo_push    = mem_write & mmio_sel & (reg_sel == MMIO_TXDATA) & byte_enable[0];
    assign fifo_pop     = tx_valid & tx_ready;
    assign push_dropped = fifo_push & fifo_full & ~fifo_pop;

    franken_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (write_data[7:0]),
        .pop       (fifo_pop),
        .head      (tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign tx_valid = ~fifo_empty;
    assign gpio_out = gpio_q;

    always_ff @(posedge clk) begin
        if (mem_write && ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_enable[i]) ram[word_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (mem_write && mmio_sel && reg_sel == MMIO_GPIO)
                gpio_q <= merge_bytes(gpio_q, write_data, byte_enable);
            // A STATUS write clears the sticky flag; it cannot coincide with a push.
            if (mem_write && mmio_sel && reg_sel == MMIO_STATUS)
                overflow_q <= 1'b0;
            else if (push_dropped)
                overflow_q <= 1'b1;
        end
    end

`ifdef FRANKEN_DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    logic        cycle_load;

    assign cycle_load = mem_write & mmio_sel & (reg_sel == MMIO_CYCLE) & (byte_enable == 4'b1111);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cycle_q <= '0;
        else if (cycle_load) cycle_q <= write_data;
        else                 cycle_q <= cycle_q + 32'd1;
    end

    assign cycle_word = cycle_q;
`else
    assign cycle_word = '0;
`endif

    always_comb begin
        status_word                                        = '0;
        status_word[STATUS_EMPTY]                          = fifo_empty;
        status_word[STATUS_FULL]                           = fifo_full;
        status_word[STATUS_OVERFLOW]                       = overflow_q;
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W]    = STATUS_COUNT_W'(fifo_count);
    end

    always_comb begin
        read_data = '0;
        if (ram_sel) begin
            read_data = ram[word_idx];
        end else if (mmio_sel) begin
            case (reg_sel)
                MMIO_GPIO:   read_data = gpio_q;
                MMIO_TXDATA: read_data = '0;
                MMIO_STATUS: read_data = status_word;
                MMIO_CYCLE:  read_data = cycle_word;
                default:     read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_franken_dmem.sv
// Directed self-checking bench for franken_dmem: RAM merge, FIFO overflow and
// drain, full-FIFO push-with-pop, CYCLE register, async reset, unmapped space.
module tb_franken_dmem;

    localparam logic [31:0] A_GPIO   = 32'h1000_0000;
    localparam logic [31:0] A_TX     = 32'h1000_0004;
    localparam logic [31:0] A_STATUS = 32'h1000_0008;
    localparam logic [31:0] A_CYCLE  = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        mem_write;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    franken_dmem #(
        .DEPTH_WORDS(1024),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .mem_write   (mem_write),
        .byte_enable (byte_enable),
        .write_data  (write_data),
        .read_data   (read_data),
        .gpio_out    (gpio_out),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr        = a;
        write_data  = d;
        byte_enable = be;
        mem_write   = 1'b1;
        tick();
        mem_write   = 1'b0;
        byte_enable = 4'b0000;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expected);
        addr = a;
        #1;
        chk(tag, read_data, expected);
    endtask

    initial begin
        reset       = 1'b0;
        addr        = 32'h0;
        mem_write   = 1'b0;
        byte_enable = 4'b0000;
        write_data  = 32'h0;
        tx_ready    = 1'b0;

        // Reset state
        #2;
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        rd_chk("rst_status", A_STATUS, 32'h0000_0001);
        rd_chk("rst_cycle", A_CYCLE, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // RAM byte-lane merge and read-during-write
        wr(32'h0000_0000, 32'h1122_3344, 4'b1111);
        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h0000_0013, 32'hAA00_0000, 4'b1000);
        rd_chk("ram_merge", 32'h0000_0010, 32'hAAAD_BEEF);
        addr        = 32'h0000_0010;
        write_data  = 32'h0000_0000;
        byte_enable = 4'b1111;
        mem_write   = 1'b1;
        #1;
        chk("ram_rdw_pre_edge", read_data, 32'hAAAD_BEEF);
        tick();
        mem_write   = 1'b0;
        rd_chk("ram_after_write", 32'h0000_0010, 32'h0);

        // FIFO overflow with consumer stalled
        addr        = A_TX;
        write_data  = 32'h41;
        byte_enable = 4'b0001;
        mem_write   = 1'b1;
        #1;
        chk("no_bypass_valid", {31'b0, tx_valid}, 32'h0);
        tick();
        mem_write   = 1'b0;
        chk("first_push_valid", {31'b0, tx_valid}, 32'h1);
        chk("first_push_data", {24'b0, tx_data}, 32'h41);
        wr(A_TX, 32'h42, 4'b0001);
        wr(A_TX, 32'h43, 4'b0001);
        wr(A_TX, 32'h44, 4'b0001);
        wr(A_TX, 32'h45, 4'b0001);
        rd_chk("ovf_status", A_STATUS, 32'h0000_0046);
        rd_chk("txdata_reads_zero", A_TX, 32'h0);
        tx_ready = 1'b1;
        #1;
        chk("drain0", {24'b0, tx_data}, 32'h41);
        tick();
        chk("drain1", {24'b0, tx_data}, 32'h42);
        tick();
        chk("drain2", {24'b0, tx_data}, 32'h43);
        tick();
        chk("drain3", {24'b0, tx_data}, 32'h44);
        chk("drain3_valid", {31'b0, tx_valid}, 32'h1);
        tick();
        chk("drain_done_valid", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd_chk("empty_status_ovf", A_STATUS, 32'h0000_0005);
        wr(A_STATUS, 32'h0, 4'b0000);
        rd_chk("ovf_cleared", A_STATUS, 32'h0000_0001);

        // Full FIFO: push and pop in the same cycle
        wr(A_TX, 32'h61, 4'b0001);
        wr(A_TX, 32'h62, 4'b0001);
        wr(A_TX, 32'h63, 4'b0001);
        wr(A_TX, 32'h64, 4'b0001);
        rd_chk("full_status", A_STATUS, 32'h0000_0042);
        addr        = A_TX;
        write_data  = 32'h55;
        byte_enable = 4'b0001;
        mem_write   = 1'b1;
        tx_ready    = 1'b1;
        tick();
        mem_write   = 1'b0;
        tx_ready    = 1'b0;
        rd_chk("push_pop_status", A_STATUS, 32'h0000_0042);
        chk("pp_head0", {24'b0, tx_data}, 32'h62);
        tx_ready = 1'b1;
        tick();
        chk("pp_head1", {24'b0, tx_data}, 32'h63);
        tick();
        chk("pp_head2", {24'b0, tx_data}, 32'h64);
        tick();
        chk("pp_last_0x55", {24'b0, tx_data}, 32'h55);
        tick();
        chk("pp_empty_valid", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // CYCLE register
`ifdef FRANKEN_DMEM_CYCLE_COUNTER_EN
        wr(A_CYCLE, 32'hFFFF_FFFE, 4'b1111);
        rd_chk("cyc_loaded", A_CYCLE, 32'hFFFF_FFFE);
        tick();
        rd_chk("cyc_max", A_CYCLE, 32'hFFFF_FFFF);
        tick();
        rd_chk("cyc_wrap", A_CYCLE, 32'h0000_0000);
        wr(A_CYCLE, 32'h0000_FFFF, 4'b0011);
        rd_chk("cyc_partial_ignored", A_CYCLE, 32'h0000_0001);
        tick();
        rd_chk("cyc_counting", A_CYCLE, 32'h0000_0002);
`else
        wr(A_CYCLE, 32'hFFFF_FFFE, 4'b1111);
        rd_chk("cyc_disabled0", A_CYCLE, 32'h0);
        tick();
        rd_chk("cyc_disabled1", A_CYCLE, 32'h0);
        wr(A_CYCLE, 32'h0000_FFFF, 4'b0011);
        rd_chk("cyc_disabled2", A_CYCLE, 32'h0);
`endif

        // GPIO merge, then asynchronous reset mid-cycle
        wr(A_TX, 32'h71, 4'b0001);
        wr(A_TX, 32'h72, 4'b0001);
        wr(A_GPIO, 32'h1234_5678, 4'b1111);
        chk("gpio_full", gpio_out, 32'h1234_5678);
        wr(A_GPIO, 32'h00AB_0000, 4'b0100);
        rd_chk("gpio_merge", A_GPIO, 32'h12AB_5678);
        chk("pre_reset_valid", {31'b0, tx_valid}, 32'h1);
        addr  = A_STATUS;
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, tx_valid}, 32'h0);
        chk("async_rst_gpio", gpio_out, 32'h0);
        chk("async_rst_tx_data", {24'b0, tx_data}, 32'h0);
        chk("async_rst_status", read_data, 32'h0000_0001);
        #1;
        reset = 1'b1;
        tick();
`ifdef FRANKEN_DMEM_CYCLE_COUNTER_EN
        rd_chk("cyc_after_reset", A_CYCLE, 32'h0000_0001);
`else
        rd_chk("cyc_after_reset", A_CYCLE, 32'h0);
`endif

        // Unmapped and out-of-range addresses
        wr(32'h2000_0000, 32'hCAFE_F00D, 4'b1111);
        rd_chk("unmapped_read", 32'h2000_0000, 32'h0);
        wr(32'h0000_1000, 32'h5A5A_5A5A, 4'b1111);
        rd_chk("past_ram_read", 32'h0000_1000, 32'h0);
        rd_chk("ram_word0_intact", 32'h0000_0000, 32'h1122_3344);
        rd_chk("mmio_hole_read", 32'h1000_0010, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
